fft_reorder_buffer: RTL and testbench
=====================================

Name: fft_reorder_buffer

Overview:
- Downstream neighbour of the 8-point radix-2 butterfly stage. Captures the 8 complex results of one frame, which arrive in bit-reversed order each tagged with a 3-bit index.
- Re-emits the frame in natural frequency order on a valid/ready stream with a frame-last marker.
- Ping-pong double buffering lets one frame be written while the previous frame drains.

Parameters:
- SIZE_OF_SIGNAL, 50, width of one complex word: real in [SIZE_OF_SIGNAL-1:SIZE_OF_SIGNAL/2], imaginary in [SIZE_OF_SIGNAL/2-1:0], both signed two's complement.
- NUM_POINTS, 8, points per frame. Fixed at 8; index width is 3.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_data_i  in  SIZE_OF_SIGNAL  butterfly result word.
- in_idx_i  in  3  butterfly output position, 0..7, bit-reversed relative to frequency bin.
- in_valid_i  in  1  in_data_i and in_idx_i are valid.
- in_ready_o  out  1  block can accept a word this cycle.
- out_data_o  out  SIZE_OF_SIGNAL  result word in natural bin order.
- out_idx_o  out  3  frequency bin of out_data_o.
- out_valid_o  out  1  out_data_o is valid.
- out_ready_i  in  1  consumer accepts out_data_o.
- out_last_o  out  1  high together with out_valid_o on bin 7.
- frame_err_o  out  1  one-cycle pulse: a frame committed with an incomplete index mask.

Behaviour:
- Reset: synchronous and active-high. Clears both banks to EMPTY, pointers and counters to 0, and every write mask.
  - While rst_i is high: out_valid_o=0, out_last_o=0, frame_err_o=0, in_ready_o=0, out_idx_o=0. out_data_o holds no defined value.
  - In the first cycle after rst_i falls, in_ready_o=1.
- Banks: two 8-entry banks. Each bank has a state EMPTY, FILLING, FULL or READING, plus an 8-bit written mask.
  - wr_bank selects the bank being written; rd_bank selects the bank being read. Both toggle 0/1.
- Write side:
  - in_ready_o = 1 iff bank[wr_bank] is EMPTY or FILLING.
  - Accept: in_valid_i && in_ready_o. On accept, store in_data_i at bank[wr_bank][bitrev3(in_idx_i)], set the matching mask bit, and increment wr_cnt.
  - The first accept moves the bank EMPTY->FILLING.
  - bitrev3 mapping: 0->0, 1->4, 2->2, 3->6, 4->1, 5->5, 6->3, 7->7.
  - A duplicate index in the same frame overwrites the earlier word. The mask is unchanged, and the duplicate still counts toward wr_cnt.
  - When the 8th accept occurs: the bank goes FILLING->FULL, wr_cnt resets to 0, and wr_bank toggles.
  - If the mask, including the bit set this cycle, is not all ones, frame_err_o pulses in the next cycle. The frame is still committed.
- Read side:
  - out_valid_o = 1 iff bank[rd_bank] is FULL or READING.
  - out_data_o = bank[rd_bank][rd_ptr]; out_idx_o = rd_ptr; out_last_o = out_valid_o && rd_ptr==7.
  - Transfer: out_valid_o && out_ready_i. The first transfer moves FULL->READING, and each transfer increments rd_ptr.
  - Transfer with out_last_o: bank goes to EMPTY, its mask clears, rd_ptr wraps to 0, and rd_bank toggles.
  - While out_ready_i is low, out_data_o, out_idx_o and out_last_o hold stable.
  - Unwritten entries output whatever the bank held previously. No zero-fill.
- Latency: the 8th write accept at cycle T gives out_valid_o=1 at T+1, if the read side is idle.
- Full condition: both banks FULL or READING makes in_ready_o=0. Upstream must hold its word until in_ready_o returns.
- Simultaneous events:
  - A write to one bank and a read of the other in the same cycle are independent.
  - A last read transfer and a first write into the same bank cannot coincide, because in_ready_o uses the registered state. The freed bank accepts from the next cycle.
- Reset mid-frame: partial write data and an in-progress read are discarded. No out_last_o is produced for the aborted frame.
- Throughput: sustained 1 word/cycle in and out with out_ready_i held at 1.

Decomposition:
- Shared package fft_pkg holds:
  - SIZE_OF_SIGNAL, NUM_POINTS and IDX_W=3;
  - the enum bank_state_e {EMPTY, FILLING, FULL, READING};
  - the function bitrev3;
  - the helpers re_of and im_of that slice a complex word.
- Sub-module fft_reorder_bank: one 8-entry storage array, written mask, and state register. Instantiated twice. The top level holds wr_bank, rd_bank, wr_cnt, rd_ptr, the handshakes and the error pulse.

Test Plan:
- Natural frame: reset, then write idx 0..7 with data=idx*0x10, out_ready_i=1. Outputs are bins 0..7 with data {0x00,0x40,0x20,0x60,0x10,0x50,0x30,0x70}; out_last_o high only on bin 7; first out_valid_o one cycle after the 8th accept.
- Back-pressure: out_ready_i=0 while three frames are offered. in_ready_o drops after 16 accepts; the 17th word is held by upstream. Raising out_ready_i drains frame 1 and then frame 2 in order, with no data loss.
- Overlap: stream two frames back-to-back with out_ready_i=1. No idle cycle on in_ready_o, and frame 2 output starts the cycle after frame 1's out_last_o transfer.
- Duplicate index: write idx 3 twice (0xAA then 0xBB) and omit idx 5. frame_err_o pulses once after the 8th accept; bin 6 outputs 0xBB; the frame still drains with out_last_o.
- Stall stability: assert out_ready_i=0 mid-frame at bin 4 for 5 cycles. out_data_o, out_idx_o=4 and out_last_o=0 stay constant; reading resumes at bin 4.
- Reset mid-frame: after 5 accepts, pulse rst_i for 1 cycle. Outputs are cleared; in_ready_o=1 the next cycle; a fresh full frame then outputs correctly with exactly one out_last_o.

Source files
------------

// File: rtl/fft_reorder_buffer_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
package fft_pkg;

   localparam int SIZE_OF_SIGNAL = 50;
   localparam int NUM_POINTS     = 8;
   localparam int IDX_W          = 3;

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_e;

   // Per-bank strobes generated by the top-level handshake logic.
   typedef struct packed {
      logic wr_en;    // accept into this bank
      logic commit;   // this accept completes the frame
      logic rd_xfer;  // output transfer from this bank
      logic rd_last;  // that transfer is bin 7
   } bank_ctrl_t;

   // Butterfly position -> frequency bin.
   function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] i);
      return {i[0], i[1], i[2]};
   endfunction

   function automatic logic signed [SIZE_OF_SIGNAL/2-1:0] re_of(input logic [SIZE_OF_SIGNAL-1:0] w);
      return w[SIZE_OF_SIGNAL-1:SIZE_OF_SIGNAL/2];
   endfunction

   function automatic logic signed [SIZE_OF_SIGNAL/2-1:0] im_of(input logic [SIZE_OF_SIGNAL-1:0] w);
      return w[SIZE_OF_SIGNAL/2-1:0];
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One 8-entry frame bank: storage, written mask and lifecycle state.
module fft_reorder_bank
   import fft_pkg::*;
#(
   parameter int W = SIZE_OF_SIGNAL
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  bank_ctrl_t             ctrl,
   input  logic [IDX_W-1:0]       wr_addr,
   input  logic [W-1:0]           wr_data,
   input  logic [IDX_W-1:0]       rd_addr,
   output logic [W-1:0]           rd_data,
   output logic [NUM_POINTS-1:0]  mask,
   output bank_state_e            state
);

   logic [NUM_POINTS-1:0][W-1:0] mem;

   // Storage is deliberately not reset: unwritten bins replay stale contents.
   always_ff @(posedge clk_i) begin
      if (ctrl.wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

   // Lifecycle: writes and reads never target the same bank in one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= EMPTY;
         mask  <= '0;
      end else if (ctrl.wr_en) begin
         mask[wr_addr] <= 1'b1;
         state         <= ctrl.commit ? FULL : FILLING;
      end else if (ctrl.rd_xfer) begin
         if (ctrl.rd_last) begin
            state <= EMPTY;
            mask  <= '0;
         end else begin
            state <= READING;
         end
      end
   end

endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: bit-reversed butterfly output in, natural bin order out.
module fft_reorder_buffer #(
   parameter int SIZE_OF_SIGNAL = 50,
   parameter int NUM_POINTS     = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [SIZE_OF_SIGNAL-1:0] in_data_i,
   input  logic [2:0]                in_idx_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   output logic [SIZE_OF_SIGNAL-1:0] out_data_o,
   output logic [2:0]                out_idx_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      out_last_o,
   output logic                      frame_err_o
);
   import fft_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

   logic                               wr_bank, rd_bank;
   logic [IDX_W-1:0]                   wr_cnt, rd_ptr, wr_addr;
   logic                               frame_err_q;
   logic                               accept, commit, xfer;
   logic [1:0][SIZE_OF_SIGNAL-1:0]     rd_data;
   logic [1:0][NUM_POINTS-1:0]         mask;
   logic [NUM_POINTS-1:0]              mask_next;
   bank_state_e                        state [2];
   bank_state_e                        wr_state, rd_state;

   assign wr_addr  = bitrev3(in_idx_i);
   assign wr_state = state[wr_bank];
   assign rd_state = state[rd_bank];

   // Handshakes come from registered bank state, so a bank freed by the last
   // read only starts accepting on the following cycle.
   assign in_ready_o  = !rst_i && (wr_state == EMPTY || wr_state == FILLING);
   assign out_valid_o = !rst_i && (rd_state == FULL  || rd_state == READING);
   assign out_last_o  = out_valid_o && (rd_ptr == LAST_IDX);
   assign out_idx_o   = rst_i ? '0 : rd_ptr;
   assign out_data_o  = rd_data[rd_bank];
   assign frame_err_o = frame_err_q && !rst_i;

   assign accept    = in_valid_i && in_ready_o;
   assign commit    = accept && (wr_cnt == LAST_IDX);
   assign xfer      = out_valid_o && out_ready_i;
   assign mask_next = mask[wr_bank] | (NUM_POINTS'(1) << wr_addr);

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         bank_ctrl_t ctrl;
         assign ctrl.wr_en   = accept && (wr_bank == 1'(b));
         assign ctrl.commit  = commit;
         assign ctrl.rd_xfer = xfer && (rd_bank == 1'(b));
         assign ctrl.rd_last = out_last_o;

         fft_reorder_bank #(.W(SIZE_OF_SIGNAL)) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .ctrl    (ctrl),
            .wr_addr (wr_addr),
            .wr_data (in_data_i),
            .rd_addr (rd_ptr),
            .rd_data (rd_data[b]),
            .mask    (mask[b]),
            .state   (state[b])
         );
      end
   endgenerate

   // Write/read pointers, bank selects and the incomplete-frame pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_cnt      <= '0;
         rd_ptr      <= '0;
         frame_err_q <= 1'b0;
      end else begin
         // Duplicates still count, so a short mask is only visible at commit.
         frame_err_q <= commit && (mask_next != '1);
         if (accept) begin
            if (commit) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt  <= wr_cnt + 3'd1;
            end
         end
         if (xfer) begin
            if (out_last_o) begin
               rd_ptr  <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               rd_ptr  <= rd_ptr + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Self-checking bench for fft_reorder_buffer: table vectors, scoreboard, corner sequences.
module tb_fft_reorder_buffer;

   localparam int W = 50;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [W-1:0] in_data_i = '0;
   logic [2:0]   in_idx_i = '0;
   logic         in_valid_i = 1'b0;
   logic         in_ready_o;
   logic [W-1:0] out_data_o;
   logic [2:0]   out_idx_o;
   logic         out_valid_o;
   logic         out_ready_i = 1'b0;
   logic         out_last_o;
   logic         frame_err_o;

   fft_reorder_buffer #(.SIZE_OF_SIGNAL(W), .NUM_POINTS(8)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_data_i   (in_data_i),
      .in_idx_i    (in_idx_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_idx_o   (out_idx_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_last_o  (out_last_o),
      .frame_err_o (frame_err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Butterfly position -> frequency bin, written out as a table.
   function automatic int rev3(input int i);
      case (i)
         0: return 0;  1: return 4;  2: return 2;  3: return 6;
         4: return 1;  5: return 5;  6: return 3;  default: return 7;
      endcase
   endfunction

   // ---------------- scoreboard / reference model ----------------
   typedef struct { logic [2:0] bin; logic [W-1:0] data; logic last; } exp_t;
   exp_t         sb_q[$];
   logic [W-1:0] mdl_mem [2][8];
   logic [7:0]   mdl_mask = '0;
   int           mcnt = 0, mwb = 0, nfull = 0;
   logic         err_exp = 1'b0;
   int           last_cyc = 0, prev_last_cyc = 0;

   always @(negedge clk_i) begin
      int nf_next;
      if (rst_i) begin
         chk("rst_out_valid", out_valid_o, 0);
         chk("rst_out_last", out_last_o, 0);
         chk("rst_frame_err", frame_err_o, 0);
         chk("rst_in_ready", in_ready_o, 0);
         chk("rst_out_idx", out_idx_o, 0);
         sb_q.delete();
         mcnt = 0; mwb = 0; mdl_mask = '0; nfull = 0; err_exp = 1'b0;
      end else begin
         chk("in_ready", in_ready_o, nfull < 2);
         chk("out_valid", out_valid_o, nfull > 0);
         chk("frame_err", frame_err_o, err_exp);
         err_exp = 1'b0;
         nf_next = nfull;
         if (in_valid_i && in_ready_o) begin
            int bin;
            bin = rev3(int'(in_idx_i));
            mdl_mem[mwb][bin] = in_data_i;
            mdl_mask[bin] = 1'b1;
            mcnt++;
            if (mcnt == 8) begin
               err_exp = (mdl_mask != 8'hFF);
               for (int b = 0; b < 8; b++)
                  sb_q.push_back('{bin: 3'(b), data: mdl_mem[mwb][b], last: (b == 7)});
               mwb ^= 1; mcnt = 0; mdl_mask = '0; nf_next++;
            end
         end
         if (out_valid_o && out_ready_i) begin
            chk("sb_has_entry", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sb_idx", out_idx_o, e.bin);
               chk("sb_data", out_data_o, e.data);
               chk("sb_last", out_last_o, e.last);
               if (e.last) begin
                  nf_next--;
                  prev_last_cyc = last_cyc;
                  last_cyc = cyc;
               end
            end
         end
         nfull = nf_next;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic put(input logic [2:0] idx, input logic [W-1:0] d);
      in_valid_i = 1'b1; in_idx_i = idx; in_data_i = d;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk_i);
         if (in_ready_o) break;
      end
      chk("put_accept", in_ready_o, 1);
      @(posedge clk_i); #1;
   endtask

   task automatic collect(output logic [W-1:0] d [8], output int nlast);
      nlast = 0;
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (out_valid_o && out_ready_i) break;
         end
         chk("collect_valid", out_valid_o, 1);
         d[out_idx_o] = out_data_o;
         nlast += int'(out_last_o);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && sb_q.size() > 0; n++) @(negedge clk_i);
      chk("drain_empty", sb_q.size(), 0);
      @(posedge clk_i); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   typedef struct { logic [2:0] idx; logic [W-1:0] din; logic [W-1:0] dout; } vec_t;
   vec_t tbl [8];

   initial begin
      logic [W-1:0] got [8];
      int nl, t0;

      tbl[0] = '{3'd0, 50'h00, 50'h00};
      tbl[1] = '{3'd1, 50'h10, 50'h40};
      tbl[2] = '{3'd2, 50'h20, 50'h20};
      tbl[3] = '{3'd3, 50'h30, 50'h60};
      tbl[4] = '{3'd4, 50'h40, 50'h10};
      tbl[5] = '{3'd5, 50'h50, 50'h50};
      tbl[6] = '{3'd6, 50'h60, 50'h30};
      tbl[7] = '{3'd7, 50'h70, 50'h70};

      // Reset state
      repeat (3) @(negedge clk_i);
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_in_ready", in_ready_o, 1);
      chk("post_rst_out_valid", out_valid_o, 0);
      @(posedge clk_i); #1;

      // Natural frame, table driven
      out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) put(tbl[i].idx, tbl[i].din);
      in_valid_i = 1'b0;
      @(negedge clk_i);
      chk("nat_latency", out_valid_o, 1);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk_i);
         chk("nat_bin", out_idx_o, i);
         chk("nat_data", out_data_o, tbl[i].dout);
         chk("nat_last", out_last_o, i == 7);
      end
      @(negedge clk_i);
      chk("nat_idle", out_valid_o, 0);
      @(posedge clk_i); #1;

      // Back-pressure: two frames fill both banks, the third word is held
      out_ready_i = 1'b0;
      for (int f = 1; f <= 2; f++)
         for (int i = 0; i < 8; i++) put(3'(i), W'(f * 'h100 + i));
      in_valid_i = 1'b1; in_idx_i = 3'd0; in_data_i = W'('h300);
      repeat (3) begin
         @(negedge clk_i);
         chk("bp_in_ready_low", in_ready_o, 0);
      end
      @(posedge clk_i); #1 out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) put(3'(i), W'('h300 + i));
      in_valid_i = 1'b0;
      drain();

      // Overlap: two frames back to back, continuous in and out
      t0 = cyc;
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 8; i++) put(3'(i), W'('h400 + f * 'h10 + i));
      in_valid_i = 1'b0;
      chk("ovl_in_cycles", cyc - t0, 16);
      drain();
      chk("ovl_last_gap", last_cyc - prev_last_cyc, 8);

      // Duplicate index 3, index 5 missing
      out_ready_i = 1'b0;
      put(3'd0, W'('h01)); put(3'd1, W'('h02)); put(3'd2, W'('h03));
      put(3'd3, W'('hAA)); put(3'd3, W'('hBB)); put(3'd4, W'('h06));
      put(3'd6, W'('h07)); put(3'd7, W'('h08));
      in_valid_i = 1'b0;
      @(negedge clk_i);
      chk("dup_err_pulse", frame_err_o, 1);
      @(negedge clk_i);
      chk("dup_err_once", frame_err_o, 0);
      @(posedge clk_i); #1 out_ready_i = 1'b1;
      collect(got, nl);
      chk("dup_bin6", got[6], 50'hBB);
      chk("dup_bin1", got[1], 50'h06);
      chk("dup_lasts", nl, 1);
      drain();

      // Stall at bin 4 for 5 cycles
      out_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) put(3'(i), W'('h500 + i));
      in_valid_i = 1'b0;
      @(posedge clk_i); #1 out_ready_i = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk_i);
         if (out_valid_o && out_idx_o == 3'd3) break;
      end
      chk("stall_reach_bin3", out_idx_o, 3);
      @(posedge clk_i); #1 out_ready_i = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         chk("stall_valid", out_valid_o, 1);
         chk("stall_idx", out_idx_o, 4);
         chk("stall_data", out_data_o, 50'h501);
         chk("stall_last", out_last_o, 0);
      end
      @(posedge clk_i); #1 out_ready_i = 1'b1;
      @(negedge clk_i);
      chk("stall_resume_idx", out_idx_o, 4);
      drain();

      // Reset in the middle of a frame
      for (int i = 0; i < 5; i++) put(3'(i), W'('h600 + i));
      in_valid_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("mid_rst_in_ready", in_ready_o, 0);
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("mid_rst_ready_after", in_ready_o, 1);
      chk("mid_rst_no_valid", out_valid_o, 0);
      @(posedge clk_i); #1;
      for (int i = 0; i < 8; i++) put(3'(i), W'('h700 + i));
      in_valid_i = 1'b0;
      collect(got, nl);
      for (int b = 0; b < 8; b++) chk("mid_rst_data", got[b], W'('h700 + rev3(b)));
      chk("mid_rst_lasts", nl, 1);
      @(negedge clk_i);
      chk("mid_rst_idle", out_valid_o, 0);

      chk("sb_empty_end", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
